mvm_noc_injector: RTL and testbench

- Host-side AXI-S transmitter feeding the mesh NoC local input port of a tile.
- Accepts one wide payload command (destination plus PAYLOADW-bit word, e.g. an MVM instruction, vector or matrix row). Serializes it into TDATAW-wide flits with constant tdest and tlast on the final beat.
- Counts completed packets so test harnesses and top-level sequencers can detect completion.

---
 rtl/mvm_noc_injector_pkg.sv | 23 ++
 rtl/mvm_noc_injector.sv | 87 ++++++++
 tb/tb_mvm_noc_injector.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_noc_injector_pkg.sv
// Shared NoC injector definitions: default widths, beat math helpers and the FSM state type.
package mvm_noc_injector_pkg;

  localparam int PAYLOADW_DEF = 512;
  localparam int TDATAW_DEF   = 32;
  localparam int DESTW_DEF    = 4;
  localparam int CNTW_DEF     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } inj_state_t;

  function automatic int beats_of(input int payloadw, input int tdataw);
    return payloadw / tdataw;
  endfunction

  // A single-beat packet still needs a 1-bit counter to keep the port widths legal.
  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mvm_noc_injector.sv
// Host-side AXI-S injector: serializes one wide command into LSB-first flits toward the NoC
// and counts fully transmitted packets.
module mvm_noc_injector
  import mvm_noc_injector_pkg::*;
#(
  parameter int PAYLOADW = PAYLOADW_DEF,
  parameter int TDATAW   = TDATAW_DEF,
  parameter int DESTW    = DESTW_DEF,
  parameter int CNTW     = CNTW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DESTW-1:0]    cmd_dest,
  input  logic [PAYLOADW-1:0] cmd_data,
  output logic                axis_tx_tvalid,
  input  logic                axis_tx_tready,
  output logic [TDATAW-1:0]   axis_tx_tdata,
  output logic [DESTW-1:0]    axis_tx_tdest,
  output logic                axis_tx_tlast,
  output logic                busy,
  output logic [CNTW-1:0]     pkt_count
);

  localparam int BEATS = beats_of(PAYLOADW, TDATAW);
  localparam int BEATW = beat_width(BEATS);
  // Beat index whose transfer makes the following beat the last one.
  localparam logic [BEATW-1:0] PENULT = (BEATS > 1) ? BEATW'(BEATS - 2) : '0;
  localparam logic             ONE_BEAT = (BEATS == 1);

  inj_state_t          state_q;
  logic [PAYLOADW-1:0] shift_q;
  logic [DESTW-1:0]    dest_q;
  logic [BEATW-1:0]    beat_q;
  logic                last_q;
  logic [CNTW-1:0]     cnt_q;

  logic xfer;
  logic fin;
  logic cmd_fire;

  assign xfer     = (state_q == SEND) && axis_tx_tready;
  assign fin      = xfer && last_q;
  // Ready on the final beat lets the next packet follow without a bubble.
  assign cmd_ready = (state_q == IDLE) || fin;
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      dest_q  <= '0;
      beat_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (fin) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
      if (cmd_fire) begin
        state_q <= SEND;
        shift_q <= cmd_data;
        dest_q  <= cmd_dest;
        beat_q  <= '0;
        last_q  <= ONE_BEAT;
      end else if (xfer) begin
        shift_q <= shift_q >> TDATAW;
        beat_q  <= beat_q + BEATW'(1);
        if (last_q) begin
          state_q <= IDLE;
          last_q  <= 1'b0;
        end else begin
          last_q  <= (beat_q == PENULT);
        end
      end
    end
  end

  assign axis_tx_tvalid = (state_q == SEND);
  assign axis_tx_tdata  = shift_q[TDATAW-1:0];
  assign axis_tx_tdest  = dest_q;
  assign axis_tx_tlast  = last_q;
  assign busy           = (state_q == SEND);
  assign pkt_count      = cnt_q;

endmodule

// File: tb/tb_mvm_noc_injector.sv
// Directed bench for mvm_noc_injector: default 16-beat instance plus a single-beat, 2-bit-counter instance.
module tb_mvm_noc_injector;

  localparam int PW = 512;
  localparam int TW = 32;
  localparam int DW = 4;
  localparam int CW = 16;
  localparam int NB = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_dest;
  logic [PW-1:0] cmd_data;
  logic          tx_tvalid;
  logic          tx_tready;
  logic [TW-1:0] tx_tdata;
  logic [DW-1:0] tx_tdest;
  logic          tx_tlast;
  logic          busy;
  logic [CW-1:0] pkt_count;

  logic          s_cmd_valid;
  logic          s_cmd_ready;
  logic [DW-1:0] s_cmd_dest;
  logic [TW-1:0] s_cmd_data;
  logic          s_tvalid;
  logic          s_tready;
  logic [TW-1:0] s_tdata;
  logic [DW-1:0] s_tdest;
  logic          s_tlast;
  logic          s_busy;
  logic [1:0]    s_pkt;

  mvm_noc_injector u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest), .cmd_data(cmd_data),
    .axis_tx_tvalid(tx_tvalid), .axis_tx_tready(tx_tready), .axis_tx_tdata(tx_tdata),
    .axis_tx_tdest(tx_tdest), .axis_tx_tlast(tx_tlast), .busy(busy), .pkt_count(pkt_count)
  );

  mvm_noc_injector #(.PAYLOADW(32), .TDATAW(32), .DESTW(4), .CNTW(2)) u_small (
    .clk(clk), .rst(rst),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_dest(s_cmd_dest), .cmd_data(s_cmd_data),
    .axis_tx_tvalid(s_tvalid), .axis_tx_tready(s_tready), .axis_tx_tdata(s_tdata),
    .axis_tx_tdest(s_tdest), .axis_tx_tlast(s_tlast), .busy(s_busy), .pkt_count(s_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_pkt  = 0;

  logic [TW-1:0] exp_data [64];
  logic [DW-1:0] exp_dest [64];
  logic          exp_last [64];
  logic [PW-1:0] q_data [$];
  logic [DW-1:0] q_dest [$];

  int vcnt;
  int bubbles;
  int first_vcyc;
  int acc_cyc [$];
  int acc_flit [$];

  function automatic logic [PW-1:0] junk();
    logic [PW-1:0] r;
    for (int i = 0; i < NB; i++) r[i*TW +: TW] = $urandom;
    return r;
  endfunction

  task automatic push_pkt(input int off, input logic [TW-1:0] base, input logic [DW-1:0] dest);
    logic [PW-1:0] d;
    for (int k = 0; k < NB; k++) begin
      d[k*TW +: TW]      = base + TW'(k);
      exp_data[off + k]  = base + TW'(k);
      exp_dest[off + k]  = dest;
      exp_last[off + k]  = (k == NB - 1);
    end
    q_data.push_back(d);
    q_dest.push_back(dest);
  endtask

  // mode 0: tready always 1; mode 1: tready alternates 0,1 per valid cycle; mode 2: 10 held cycles then 1
  task automatic collect(input int n, input int mode);
    int idx = 0;
    int cyc = 0;
    bit started = 0;
    bit hold = 0;
    logic [TW-1:0] h_data;
    logic [DW-1:0] h_dest;
    logic          h_last;
    vcnt = 0; bubbles = 0; first_vcyc = -1;
    acc_cyc.delete(); acc_flit.delete();
    while (idx < n && cyc < 400) begin
      @(negedge clk);
      case (mode)
        0:       tx_tready = 1'b1;
        1:       tx_tready = vcnt[0];
        default: tx_tready = (vcnt >= 10);
      endcase
      if (q_data.size() > 0) begin
        cmd_valid = 1'b1; cmd_data = q_data[0]; cmd_dest = q_dest[0];
      end else begin
        cmd_valid = 1'b0; cmd_data = junk(); cmd_dest = DW'($urandom);
      end
      #1;
      if (cmd_valid && cmd_ready) begin
        acc_cyc.push_back(cyc);
        acc_flit.push_back((tx_tvalid && tx_tready) ? idx : -1);
        void'(q_data.pop_front());
        void'(q_dest.pop_front());
      end
      if (tx_tvalid) begin
        if (first_vcyc < 0) first_vcyc = cyc;
        started = 1;
        if (hold) begin
          checks++;
          if (tx_tdata !== h_data || tx_tdest !== h_dest || tx_tlast !== h_last) begin
            failures++;
            $display("FAIL hold_stable flit=%0d got data=%h dest=%h last=%b want data=%h dest=%h last=%b",
                     idx, tx_tdata, tx_tdest, tx_tlast, h_data, h_dest, h_last);
          end
        end
        checks++;
        if (tx_tdata !== exp_data[idx] || tx_tdest !== exp_dest[idx] || tx_tlast !== exp_last[idx] || busy !== 1'b1) begin
          failures++;
          $display("FAIL flit%0d got data=%h dest=%h last=%b busy=%b want data=%h dest=%h last=%b busy=1",
                   idx, tx_tdata, tx_tdest, tx_tlast, busy, exp_data[idx], exp_dest[idx], exp_last[idx]);
        end
        if (tx_tready) begin
          idx++; hold = 0;
        end else begin
          hold = 1; h_data = tx_tdata; h_dest = tx_tdest; h_last = tx_tlast;
        end
        vcnt++;
      end else if (started) begin
        bubbles++;
      end
      cyc++;
    end
    if (idx < n) begin
      checks++; failures++;
      $display("FAIL collect_timeout got %0d flits want %0d", idx, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_dest = '0; cmd_data = '0; tx_tready = 1'b0;
    s_cmd_valid = 1'b0; s_cmd_dest = '0; s_cmd_data = '0; s_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_tvalid !== 1'b0 || tx_tlast !== 1'b0 || tx_tdata !== '0 || tx_tdest !== '0 || busy !== 1'b0 || pkt_count !== '0) begin
      failures++;
      $display("FAIL reset_values got tvalid=%b tlast=%b tdata=%h tdest=%h busy=%b pkt=%0d want all zero",
               tx_tvalid, tx_tlast, tx_tdata, tx_tdest, busy, pkt_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || tx_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_reset got cmd_ready=%b tvalid=%b want 1 0", cmd_ready, tx_tvalid);
    end
    exp_pkt = 0;
  endtask

  task automatic test_single();
    push_pkt(0, 32'h0000_0000, 4'h3);
    collect(16, 0);
    exp_pkt++;
    checks++;
    if (acc_cyc.size() != 1 || first_vcyc - acc_cyc[0] != 1) begin
      failures++;
      $display("FAIL single_latency got accepts=%0d first_valid=%0d want 1 accept, beat0 one cycle after", acc_cyc.size(), first_vcyc);
    end
    checks++;
    if (bubbles != 0 || vcnt != 16) begin
      failures++;
      $display("FAIL single_span got bubbles=%0d valid_cycles=%0d want 0 16", bubbles, vcnt);
    end
    @(negedge clk); #1;
    checks++;
    if (tx_tvalid !== 1'b0 || busy !== 1'b0 || tx_tlast !== 1'b0 || pkt_count !== CW'(exp_pkt)) begin
      failures++;
      $display("FAIL single_end got tvalid=%b busy=%b tlast=%b pkt=%0d want 0 0 0 %0d", tx_tvalid, busy, tx_tlast, pkt_count, exp_pkt);
    end
  endtask

  task automatic test_backpressure_toggle();
    push_pkt(0, 32'h0000_0000, 4'h3);
    collect(16, 1);
    exp_pkt++;
    checks++;
    if (vcnt != 32) begin
      failures++;
      $display("FAIL toggle_cycles got %0d want 32", vcnt);
    end
    @(negedge clk); #1;
    checks++;
    if (tx_tvalid !== 1'b0 || pkt_count !== CW'(exp_pkt)) begin
      failures++;
      $display("FAIL toggle_end got tvalid=%b pkt=%0d want 0 %0d", tx_tvalid, pkt_count, exp_pkt);
    end
  endtask

  task automatic test_back_to_back();
    push_pkt(0, 32'hA000_0000, 4'h1);
    push_pkt(16, 32'hB000_0000, 4'h2);
    collect(32, 0);
    exp_pkt += 2;
    checks++;
    if (acc_flit.size() != 2 || acc_flit[1] != 15) begin
      failures++;
      $display("FAIL b2b_accept got accepts=%0d second_at_flit=%0d want 2 15", acc_flit.size(),
               (acc_flit.size() > 1) ? acc_flit[1] : -1);
    end
    checks++;
    if (bubbles != 0 || vcnt != 32) begin
      failures++;
      $display("FAIL b2b_bubbles got bubbles=%0d valid_cycles=%0d want 0 32", bubbles, vcnt);
    end
    @(negedge clk); #1;
    checks++;
    if (tx_tvalid !== 1'b0 || pkt_count !== CW'(exp_pkt)) begin
      failures++;
      $display("FAIL b2b_end got tvalid=%b pkt=%0d want 0 %0d", tx_tvalid, pkt_count, exp_pkt);
    end
  endtask

  task automatic test_reset_mid();
    push_pkt(0, 32'h5000_0000, 4'h5);
    collect(7, 0);
    @(negedge clk);
    cmd_valid = 1'b0; tx_tready = 1'b1;
    #1;
    checks++;
    if (tx_tvalid !== 1'b1 || tx_tdata !== 32'h5000_0007) begin
      failures++;
      $display("FAIL mid_beat7 got tvalid=%b data=%h want 1 50000007", tx_tvalid, tx_tdata);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (tx_tvalid !== 1'b0 || pkt_count !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got tvalid=%b pkt=%0d cmd_ready=%b busy=%b want 0 0 1 0", tx_tvalid, pkt_count, cmd_ready, busy);
    end
    rst = 1'b0;
    exp_pkt = 0;
    push_pkt(0, 32'h6000_0000, 4'h6);
    collect(16, 0);
    exp_pkt++;
    @(negedge clk); #1;
    checks++;
    if (tx_tvalid !== 1'b0 || pkt_count !== CW'(exp_pkt)) begin
      failures++;
      $display("FAIL mid_after got tvalid=%b pkt=%0d want 0 %0d", tx_tvalid, pkt_count, exp_pkt);
    end
  endtask

  task automatic test_cmd_sample();
    push_pkt(0, 32'h7700_0000, 4'h9);
    collect(16, 2);
    exp_pkt++;
    checks++;
    if (vcnt != 26) begin
      failures++;
      $display("FAIL sample_cycles got %0d want 26", vcnt);
    end
    @(negedge clk); #1;
    checks++;
    if (tx_tvalid !== 1'b0 || pkt_count !== CW'(exp_pkt)) begin
      failures++;
      $display("FAIL sample_end got tvalid=%b pkt=%0d want 0 %0d", tx_tvalid, pkt_count, exp_pkt);
    end
  endtask

  task automatic test_single_beat_wrap();
    logic [1:0] want_pkt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    s_tready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      s_cmd_valid = 1'b1; s_cmd_data = 32'hC0DE_0000 + TW'(p); s_cmd_dest = DW'(p + 2);
      #1;
      checks++;
      if (s_cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL small_ready%0d got %b want 1", p, s_cmd_ready);
      end
      @(negedge clk);
      s_cmd_valid = 1'b0; s_cmd_data = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (s_tvalid !== 1'b1 || s_tlast !== 1'b1 || s_tdata !== 32'hC0DE_0000 + TW'(p) || s_tdest !== DW'(p + 2)) begin
        failures++;
        $display("FAIL small_flit%0d got valid=%b last=%b data=%h dest=%h want 1 1 %h %h",
                 p, s_tvalid, s_tlast, s_tdata, s_tdest, 32'hC0DE_0000 + TW'(p), DW'(p + 2));
      end
      @(negedge clk); #1;
      checks++;
      if (s_tvalid !== 1'b0 || s_pkt !== want_pkt[p]) begin
        failures++;
        $display("FAIL small_pkt%0d got valid=%b pkt=%0d want 0 %0d", p, s_tvalid, s_pkt, want_pkt[p]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure_toggle();
    test_back_to_back();
    test_reset_mid();
    test_cmd_sample();
    test_single_beat_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
